// File: rtl/ct_l2c_mem_pkg.sv
// Shared definitions for the L2C memory wrappers: sequencer state encoding
// and write-mask geometry helpers.
package ct_l2c_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } seq_state_t;

    // Data bits covered by one write-mask bit.
    function automatic int grp_bits(input int data_width, input int we_width);
        return (we_width > 0) ? data_width / we_width : 0;
    endfunction

    // Mask geometry is legal only when every group is at least one bit and exact.
    function automatic bit grp_ok(input int data_width, input int we_width);
        return (we_width > 0) && (data_width >= we_width) && ((data_width % we_width) == 0);
    endfunction

endpackage

// File: rtl/ct_spsram_param_core.sv
// Raw single-port array with per-bit write enables and one registered read port.
// Stands in for the vendor macro; holds no control logic.
module ct_spsram_param_core #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 88
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] bit_we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (bit_we[b]) begin
                mem_reg[addr][b] <= d[b];
            end
        end
    end

    // Read-first: a read returns the contents before this edge's write.
    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= '0;
        end else if (rd_en) begin
            q_reg <= mem_reg[addr];
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM wrapper with an initialisation sequencer that
// fills every entry with INIT_VAL after reset or on INIT_REQ, plus a read-valid strobe.
module ct_spsram_param_init
    import ct_l2c_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 88,
    parameter int                    WE_WIDTH   = 88,
    parameter bit                    OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Q_VLD,
    input  logic                  INIT_REQ,
    output logic                  INIT_BUSY,
    output logic                  INIT_DONE
);

    localparam int GRP = grp_bits(DATA_WIDTH, WE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

    if (!grp_ok(DATA_WIDTH, WE_WIDTH)) begin : g_bad_geometry
        $error("DATA_WIDTH must be a positive integer multiple of WE_WIDTH");
    end

    seq_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  done_reg;
    logic                  rd_vld_reg;

    logic                  init_active;
    logic                  func_acc;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_d;
    logic [WE_WIDTH-1:0]   grp_we;
    logic [DATA_WIDTH-1:0] bit_we;
    logic [DATA_WIDTH-1:0] core_q;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (INIT_REQ) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_INIT;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            rd_vld_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            done_reg   <= init_active && (cnt_reg == CNT_LAST);
            rd_vld_reg <= mem_rd;
        end
    end

    // INIT_REQ takes priority over a same-cycle functional access.
    assign init_active = (state_reg == ST_INIT);
    assign func_acc    = (state_reg == ST_IDLE) && !INIT_REQ && !CEN && !RST;
    assign mem_rd      = func_acc && GWEN;
    assign mem_addr    = init_active ? cnt_reg : A;
    assign mem_d       = init_active ? INIT_VAL : D;

    always_comb begin
        grp_we = '0;
        if (init_active && !RST) begin
            grp_we = '1;
        end else if (func_acc && !GWEN) begin
            grp_we = ~WEN;
        end
    end

    for (genvar gi = 0; gi < WE_WIDTH; gi++) begin : g_mask
        assign bit_we[gi*GRP +: GRP] = {GRP{grp_we[gi]}};
    end

    ct_spsram_param_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk    (CLK),
        .srst   (RST),
        .rd_en  (mem_rd),
        .addr   (mem_addr),
        .bit_we (bit_we),
        .d      (mem_d),
        .q      (core_q)
    );

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_out_reg;
        logic                  vld_out_reg;

        always_ff @(posedge CLK) begin
            if (RST) begin
                q_out_reg   <= '0;
                vld_out_reg <= 1'b0;
            end else begin
                vld_out_reg <= rd_vld_reg;
                if (rd_vld_reg) begin
                    q_out_reg <= core_q;
                end
            end
        end

        assign Q     = q_out_reg;
        assign Q_VLD = vld_out_reg;
    end else begin : g_out_direct
        assign Q     = core_q;
        assign Q_VLD = rd_vld_reg;
    end

    assign INIT_BUSY = init_active;
    assign INIT_DONE = done_reg;

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Randomised and directed bench for ct_spsram_param_init, run against a
// behavioural memory model for both output-register configurations at once.
module tb_ct_spsram_param_init;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int WW    = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] IV = 16'hA5A5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [WW-1:0] WEN;
    logic [DW-1:0] D;
    logic          INIT_REQ;

    logic [DW-1:0] q0, q1;
    logic          vld0, vld1, busy0, busy1, done0, done1;

    always #5 CLK = ~CLK;

    ct_spsram_param_init #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WE_WIDTH (WW), .OUT_REG (1'b0), .INIT_VAL (IV)
    ) dut0 (
        .CLK (CLK), .RST (RST), .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D),
        .Q (q0), .Q_VLD (vld0), .INIT_REQ (INIT_REQ), .INIT_BUSY (busy0), .INIT_DONE (done0)
    );

    ct_spsram_param_init #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WE_WIDTH (WW), .OUT_REG (1'b1), .INIT_VAL (IV)
    ) dut1 (
        .CLK (CLK), .RST (RST), .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D),
        .Q (q1), .Q_VLD (vld1), .INIT_REQ (INIT_REQ), .INIT_BUSY (busy1), .INIT_DONE (done1)
    );

    // Behavioural reference: memory contents, remaining init cycles, and
    // per-latency queues of read results with the cycle they are due.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] m_mem [0:DEPTH-1];
    int            busy_left;
    bit            done_flag;
    rd_t           exp0[$];
    rd_t           exp1[$];
    logic [DW-1:0] last_q0, last_q1;
    int            cyc;
    bit            chk_on;
    int            n_checks;
    int            n_errors;
    int            busy_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        bit ev0, ev1;
        @(negedge CLK);
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (exp0.size() > 0 && exp0[0].due == cyc) begin
            ev0 = 1'b1; last_q0 = exp0[0].data; void'(exp0.pop_front());
        end
        if (exp1.size() > 0 && exp1[0].due == cyc) begin
            ev1 = 1'b1; last_q1 = exp1[0].data; void'(exp1.pop_front());
        end
        if (chk_on) begin
            check_eq("busy0", busy0, busy_left > 0);
            check_eq("busy1", busy1, busy_left > 0);
            check_eq("done0", done0, done_flag);
            check_eq("done1", done1, done_flag);
            check_eq("vld0", vld0, ev0);
            check_eq("vld1", vld1, ev1);
            check_eq("q0", q0, last_q0);
            check_eq("q1", q1, last_q1);
            if (ev0) $display("cyc %0d read lat1 q=%h", cyc, q0);
            if (ev1) $display("cyc %0d read lat2 q=%h", cyc, q1);
        end
        // Model transition for the edge that closes this cycle.
        if (RST) begin
            busy_left = DEPTH;
            done_flag = 1'b0;
            exp0.delete();
            exp1.delete();
            last_q0 = '0;
            last_q1 = '0;
        end else if (busy_left > 0) begin
            m_mem[DEPTH - busy_left] = IV;
            busy_left--;
            done_flag = (busy_left == 0);
        end else begin
            done_flag = 1'b0;
            if (INIT_REQ) begin
                busy_left = DEPTH;
            end else if (!CEN) begin
                if (!GWEN) begin
                    for (int g = 0; g < WW; g++)
                        if (!WEN[g]) m_mem[A][g*4 +: 4] = D[g*4 +: 4];
                end else begin
                    exp0.push_back('{due: cyc + 1, data: m_mem[A]});
                    exp1.push_back('{due: cyc + 2, data: m_mem[A]});
                end
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit rst, input bit req, input bit cen, input bit gwen,
                         input logic [AW-1:0] a, input logic [WW-1:0] wen, input logic [DW-1:0] d);
        RST = rst; INIT_REQ = req; CEN = cen; GWEN = gwen; A = a; WEN = wen; D = d;
        cycle();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '1, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WW-1:0] wen);
        drive(1'b0, 1'b0, 1'b0, 1'b0, a, wen, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, 1'b0, 1'b0, 1'b1, a, '1, '0);
    endtask

    // Counts busy cycles until the pass ends, bounded so a stuck sequencer still terminates.
    task automatic count_busy(input string tag, input int want);
        busy_run = 0;
        for (int i = 0; i < 64 && busy0; i++) begin
            busy_run++;
            nop(1);
        end
        check_eq(tag, busy_run, want);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; chk_on = 1'b0;
        busy_left = DEPTH; done_flag = 1'b0; last_q0 = '0; last_q1 = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

        drive(1'b1, 1'b0, 1'b1, 1'b1, '0, '1, '0);
        chk_on = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, '0, '1, '0);

        // Reset release with a blocked write to 15 issued during the pass.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 4'b0000, 16'h0000);
        count_busy("pass_len_rst", DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) rd(i[AW-1:0]);
        nop(2);

        // Masked write and read-after-write, then pipelined reads.
        wr(4'd3, 16'h1234, 4'b1010);
        rd(4'd3);
        wr(4'd7, 16'hBEEF, 4'b0000);
        rd(4'd7);
        rd(4'd0); rd(4'd7); rd(4'd0);
        nop(2);

        // Requested re-init with a second request mid-pass.
        wr(4'd9, 16'h5555, 4'b0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, '1, '0);
        for (int i = 0; i < 5; i++) nop(1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '1, '0);
        count_busy("pass_len_req", DEPTH - 6);
        rd(4'd9);
        nop(2);

        // Reset at counter=10 with a read in flight beforehand.
        rd(4'd9);
        drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '1, '0);
        nop(10);
        drive(1'b1, 1'b0, 1'b1, 1'b1, '0, '1, '0);
        count_busy("pass_len_midrst", DEPTH);
        nop(2);

        // Randomised traffic including occasional reset and init requests.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, DEPTH - 1)), WW'($urandom), DW'($urandom));
        end
        nop(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ct_spsram_param_init.md
# ct_spsram_param_init

Parametrised single-port SRAM wrapper for the L2C and other array-bearing units, superseding the fixed-geometry per-size wrappers. Depth, data width, write-mask granularity and read-pipeline depth are all parameters. It adds a built-in initialisation sequencer that writes a constant to every entry after reset or on request. While the sequencer runs, it blocks functional accesses and reports itself busy. A read-valid strobe is added, so consumers no longer hard-code the read latency.

## Interface
Parameters:
- ADDR_WIDTH, 11, address bits; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 88, data bits per entry.
- WE_WIDTH, 88, write-mask bits. DATA_WIDTH must be an integer multiple of WE_WIDTH; each WEN bit covers DATA_WIDTH/WE_WIDTH contiguous bits.
- OUT_REG, 0, set to 1 to add an output register stage (read latency 2 instead of 1).
- INIT_VAL, 0, DATA_WIDTH-bit value written to every entry during initialisation.

Ports:
- CLK  in  1  clock; the block uses one clock only.
- RST  in  1  reset, synchronous and active-high.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active-low.
- GWEN  in  1  global write enable, active-low. 0 = write, 1 = read.
- WEN  in  WE_WIDTH  per-group write enable, active-low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- Q_VLD  out  1  one-cycle strobe marking the cycle in which Q carries new read data.
- INIT_REQ  in  1  level/pulse that starts a full initialisation pass.
- INIT_BUSY  out  1  initialisation in progress; functional accesses are ignored while high.
- INIT_DONE  out  1  one-cycle pulse when a pass completes.

## Operation
State machine states: INIT, IDLE.
- RST=1: state←INIT, counter←0.
- INIT: each cycle, write INIT_VAL to entry `counter` with all write groups enabled, then increment `counter`. After the write to entry 2^ADDR_WIDTH−1, go to IDLE.
- IDLE: INIT_REQ=1 sets state←INIT and counter←0. Functional accesses are not accepted in that cycle.
- INIT_REQ while in INIT: ignored. It neither restarts nor extends the pass.
- Functional accesses in INIT (CEN=0): dropped. No write, no Q_VLD, Q holds its value.

Functional access in IDLE:
- Write (CEN=0, GWEN=0): bit group g is updated from D when WEN[g]=0 and keeps its old value when WEN[g]=1. Q does not change and no Q_VLD is produced.
- All WEN bits set to 1 with GWEN=0: no entry change.
- Read (CEN=0, GWEN=1): returns the entry's contents as they were before this cycle's edge.
- CEN=1: no access. Q holds its last read value.

Counter width is ADDR_WIDTH+1, or the wrap condition is detected explicitly. A pass must never terminate early or loop.

## Timing
- Reset values: Q=0, Q_VLD=0, INIT_BUSY=1, INIT_DONE=0. The array contents are not reset.
- INIT_BUSY is 1 in every INIT-state cycle and 0 in IDLE.
- Init pass length: exactly 2^ADDR_WIDTH cycles, counted from the first cycle after RST deasserts or after the INIT_REQ cycle.
- INIT_DONE is 1 in the first IDLE cycle after a pass and 0 otherwise.
- A functional access is legal from the first IDLE cycle, i.e. the cycle in which INIT_DONE=1.
- Read latency, OUT_REG=0: access at edge N gives Q valid and Q_VLD=1 after edge N+1.
- Read latency, OUT_REG=1: valid one cycle later (after edge N+2).
- Back-to-back reads are fully pipelined, one per cycle.
- Read in the cycle after a write to the same address returns the new data.
- RST asserted mid-pass: the pass restarts from entry 0 and no INIT_DONE is produced.
- RST asserted with a read in flight: Q_VLD=0 and the read is discarded.
- INIT_REQ in the same cycle as a functional access in IDLE: INIT_REQ wins and the access is dropped.

## Structure
- Shared package (ct_l2c_mem_pkg) holds: the state encoding (INIT, IDLE) and the width-check constant DATA_WIDTH/WE_WIDTH, asserted ≥1 and exact.
- Sub-module ct_spsram_param_core contains:
  - the raw array with mask-expanded bit writes;
  - one read register;
  - no control logic.
  - For FPGA and ASIC builds, the core is swapped for the vendor macro.
- The top level contains:
  - the sequencer and the address/data/mask muxes (init vs functional);
  - the optional output stage;
  - the Q_VLD pipeline.

## Test plan
Use ADDR_WIDTH=4, DATA_WIDTH=16, WE_WIDTH=4, INIT_VAL=16'hA5A5, for both OUT_REG=0 and OUT_REG=1.
- Reset release: INIT_BUSY high for exactly 16 cycles, INIT_DONE pulses once. Reading addresses 0–15 then returns 16'hA5A5 each, with Q_VLD at latency 1 or 2 as configured.
- Masked write: write D=16'h1234 with WEN=4'b1010 to address 3. A read of address 3 returns 16'hA2A4.
- Read after write: write 16'hBEEF to address 7, then read address 7 in the next cycle. The read returns 16'hBEEF. Pipelined reads of addresses 0, 7, 0 return 16'hA5A5, 16'hBEEF, 16'hA5A5 on consecutive cycles.
- Blocked access: during INIT, issue a write of 16'h0000 to address 15. After INIT_DONE, address 15 reads 16'hA5A5, and no Q_VLD appeared during the pass.
- Requested re-init: write 16'h5555 to address 9, then assert INIT_REQ in IDLE. INIT_BUSY is high for 16 cycles, and address 9 then reads 16'hA5A5. A second INIT_REQ mid-pass does not lengthen the pass.
- Reset mid-pass: assert RST at counter=10. INIT_DONE is not pulsed, and the new pass lasts a full 16 cycles after RST deasserts.
